elv_dispatch: RTL and testbench

//  Two-car, four-floor elevator dispatcher. Accepts hall calls, assigns each to the nearer car,
//  and sequences each car through move/door phases one floor at a time. Sits between the

---
 rtl/elv_pkg.sv | 59 +++++
 rtl/elv_car_fsm.sv | 136 +++++++++++++
 rtl/elv_dispatch.sv | 164 ++++++++++++++++
 tb/tb_elv_dispatch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elv_pkg
//  Description : Shared types, constants and helper functions for the
//                two-car elevator dispatcher.
//  Revision    : 1.0  initial release
// ============================================================================
package elv_pkg;

    localparam int   NUM_FLOORS = 4;
    localparam logic DIR_UP     = 1'b0;
    localparam logic DIR_DN     = 1'b1;

    typedef logic [1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } car_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CAR1 = 2'd1,
        OWN_CAR2 = 2'd2
    } owner_t;

    // Absolute floor distance, widened so it can never wrap.
    function automatic logic [2:0] floor_dist(input floor_t a, input floor_t b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

    // Nearest floor set in mask, searched in rings of growing distance;
    // the lower floor of each ring is looked at first so ties go low.
    function automatic floor_t nearest_floor(input logic [NUM_FLOORS-1:0] mask,
                                             input floor_t pos);
        floor_t best;
        logic   found;
        int     lo;
        int     hi;
        best  = pos;
        found = 1'b0;
        for (int d = 0; d < NUM_FLOORS; d++) begin
            lo = int'(pos) - d;
            hi = int'(pos) + d;
            if (!found && lo >= 0 && mask[lo[1:0]]) begin
                best  = lo[1:0];
                found = 1'b1;
            end
            if (!found && hi < NUM_FLOORS && mask[hi[1:0]]) begin
                best  = hi[1:0];
                found = 1'b1;
            end
        end
        return best;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elv_car_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : elv_car_fsm
//  Description : One elevator car: IDLE/MOVE/DOOR sequencing, floor position,
//                travel direction and a served strobe on DOOR entry.
//  Revision    : 1.0  initial release
// ============================================================================
module elv_car_fsm
    import elv_pkg::*;
#(
    parameter int         MOVE_CYCLES = 8,
    parameter int         DOOR_CYCLES = 4,
    parameter logic [1:0] INIT_POS    = 2'd0,
    parameter logic       INIT_DIR    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] i_assigned,
    input  logic                  i_hold,
    output logic [1:0]            o_pos,
    output logic                  o_dir,
    output logic                  o_mv,
    output logic                  o_door,
    output logic                  o_served,
    output logic [1:0]            o_served_floor
);

    localparam int c_tmax = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int c_tw   = (c_tmax > 1) ? $clog2(c_tmax) : 1;
    localparam logic [c_tw-1:0] c_move_load = c_tw'(MOVE_CYCLES - 1);
    localparam logic [c_tw-1:0] c_door_load = c_tw'(DOOR_CYCLES - 1);

    car_state_t      r_state;
    car_state_t      w_state_nxt;
    logic [c_tw-1:0] r_timer;
    logic [c_tw-1:0] w_timer_nxt;
    floor_t          r_pos;
    floor_t          w_pos_nxt;
    floor_t          r_target;
    floor_t          w_target_nxt;
    floor_t          w_pick;
    floor_t          w_step;
    logic            r_dir;
    logic            w_dir_nxt;
    logic            r_mv;
    logic            r_door;

    // State, timer, position and registered phase flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_timer  <= '0;
            r_pos    <= INIT_POS;
            r_target <= INIT_POS;
            r_dir    <= INIT_DIR;
            r_mv     <= 1'b0;
            r_door   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_pos    <= w_pos_nxt;
            r_target <= w_target_nxt;
            r_dir    <= w_dir_nxt;
            r_mv     <= (w_state_nxt == MOVE);
            r_door   <= (w_state_nxt == DOOR);
        end
    end

    // Next-state logic; the target is latched on leaving IDLE and never revised.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_pos_nxt    = r_pos;
        w_dir_nxt    = r_dir;
        w_target_nxt = r_target;
        w_pick       = nearest_floor(i_assigned, r_pos);
        w_step       = (r_dir == DIR_DN) ? r_pos - 2'd1 : r_pos + 2'd1;
        case (r_state)
            IDLE: begin
                if (|i_assigned) begin
                    w_target_nxt = w_pick;
                    if (w_pick == r_pos) begin
                        w_state_nxt = DOOR;
                        w_timer_nxt = c_door_load;
                    end else begin
                        w_dir_nxt   = (w_pick < r_pos) ? DIR_DN : DIR_UP;
                        w_timer_nxt = c_move_load;
                        w_state_nxt = MOVE;
                    end
                end
            end
            MOVE: begin
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - 1'b1;
                end else begin
                    w_pos_nxt = w_step;
                    if (w_step == r_target) begin
                        w_state_nxt = DOOR;
                        w_timer_nxt = c_door_load;
                    end else begin
                        w_timer_nxt = c_move_load;
                    end
                end
            end
            DOOR: begin
                if (i_hold) begin
                    w_timer_nxt = c_door_load;
                end else if (r_timer == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        o_served       = (r_state != DOOR) && (w_state_nxt == DOOR);
        o_served_floor = w_pos_nxt;
    end

    // Stepping past either end of the shaft means target selection is broken.
    always_ff @(posedge clk) begin
        if (!rst && r_state == MOVE && r_timer == '0) begin
            assert (!((r_dir == DIR_UP && r_pos == 2'd3) ||
                      (r_dir == DIR_DN && r_pos == 2'd0)));
        end
    end

    assign o_pos  = r_pos;
    assign o_dir  = r_dir;
    assign o_mv   = r_mv;
    assign o_door = r_door;

endmodule
`default_nettype wire

// File: rtl/elv_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : elv_dispatch
//  Description : Two-car, four-floor dispatcher. Holds the hall-call bitmaps
//                and floor ownership, assigns new floors to the nearer car and
//                drives two car sequencers.
//  Revision    : 1.0  initial release
// ============================================================================
module elv_dispatch
    import elv_pkg::*;
#(
    parameter int MOVE_CYCLES = 8,
    parameter int DOOR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       call_valid,
    input  logic [1:0] call_floor,
    input  logic       call_dir,
    output logic       call_ready,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic       u1,
    output logic       u2,
    output logic       mv1,
    output logic       mv2,
    output logic       door1,
    output logic       door2,
    output logic [3:0] pend
);

    logic [NUM_FLOORS-1:0] r_up_req;
    logic [NUM_FLOORS-1:0] r_dn_req;
    logic [NUM_FLOORS-1:0] w_up_nxt;
    logic [NUM_FLOORS-1:0] w_dn_nxt;
    owner_t                r_owner     [NUM_FLOORS];
    owner_t                w_owner_nxt [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] r_pend;
    logic                  r_call_ready;
    logic [NUM_FLOORS-1:0] w_assigned1;
    logic [NUM_FLOORS-1:0] w_assigned2;
    logic                  w_accept;
    logic                  w_hold1;
    logic                  w_hold2;
    logic                  w_clash;
    logic                  w_absorb;
    logic [2:0]            w_d1;
    logic [2:0]            w_d2;
    logic                  w_served1;
    logic                  w_served2;
    floor_t                w_sfloor1;
    floor_t                w_sfloor2;

    for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_mask
        assign w_assigned1[f] = (r_owner[f] == OWN_CAR1);
        assign w_assigned2[f] = (r_owner[f] == OWN_CAR2);
    end

    // A call landing on an open-door floor, or on a floor being cleared this
    // very edge, is treated as already served.
    assign w_accept = call_valid && r_call_ready;
    assign w_hold1  = w_accept && door1 && (pos1 == call_floor);
    assign w_hold2  = w_accept && door2 && (pos2 == call_floor);
    assign w_clash  = w_accept && ((w_served1 && (w_sfloor1 == call_floor)) ||
                                   (w_served2 && (w_sfloor2 == call_floor)));
    assign w_absorb = w_hold1 || w_hold2 || w_clash;
    assign w_d1     = floor_dist(pos1, call_floor);
    assign w_d2     = floor_dist(pos2, call_floor);

    // Request/ownership update: DOOR-entry clears first, then new calls.
    always_comb begin
        w_up_nxt = r_up_req;
        w_dn_nxt = r_dn_req;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            w_owner_nxt[f] = r_owner[f];
        end
        if (w_served1) begin
            w_up_nxt[w_sfloor1]    = 1'b0;
            w_dn_nxt[w_sfloor1]    = 1'b0;
            w_owner_nxt[w_sfloor1] = OWN_NONE;
        end
        if (w_served2) begin
            w_up_nxt[w_sfloor2]    = 1'b0;
            w_dn_nxt[w_sfloor2]    = 1'b0;
            w_owner_nxt[w_sfloor2] = OWN_NONE;
        end
        if (w_accept && !w_absorb) begin
            if (!(r_up_req[call_floor] || r_dn_req[call_floor])) begin
                if (w_d1 <= w_d2) begin
                    w_owner_nxt[call_floor] = OWN_CAR1;
                end else begin
                    w_owner_nxt[call_floor] = OWN_CAR2;
                end
            end
            if (call_dir == DIR_DN) begin
                w_dn_nxt[call_floor] = 1'b1;
            end else begin
                w_up_nxt[call_floor] = 1'b1;
            end
        end
    end

    // Request bitmaps, ownership table and registered pend/ready outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_up_req     <= '0;
            r_dn_req     <= '0;
            r_pend       <= '0;
            r_call_ready <= 1'b0;
            for (int f = 0; f < NUM_FLOORS; f++) begin
                r_owner[f] <= OWN_NONE;
            end
        end else begin
            r_up_req     <= w_up_nxt;
            r_dn_req     <= w_dn_nxt;
            r_pend       <= w_up_nxt | w_dn_nxt;
            r_call_ready <= 1'b1;
            for (int f = 0; f < NUM_FLOORS; f++) begin
                r_owner[f] <= w_owner_nxt[f];
            end
        end
    end

    elv_car_fsm #(
        .MOVE_CYCLES (MOVE_CYCLES),
        .DOOR_CYCLES (DOOR_CYCLES),
        .INIT_POS    (2'd0),
        .INIT_DIR    (DIR_UP)
    ) u_car1 (
        .clk            (clk),
        .rst            (rst),
        .i_assigned     (w_assigned1),
        .i_hold         (w_hold1),
        .o_pos          (pos1),
        .o_dir          (u1),
        .o_mv           (mv1),
        .o_door         (door1),
        .o_served       (w_served1),
        .o_served_floor (w_sfloor1)
    );

    elv_car_fsm #(
        .MOVE_CYCLES (MOVE_CYCLES),
        .DOOR_CYCLES (DOOR_CYCLES),
        .INIT_POS    (2'd3),
        .INIT_DIR    (DIR_DN)
    ) u_car2 (
        .clk            (clk),
        .rst            (rst),
        .i_assigned     (w_assigned2),
        .i_hold         (w_hold2),
        .o_pos          (pos2),
        .o_dir          (u2),
        .o_mv           (mv2),
        .o_door         (door2),
        .o_served       (w_served2),
        .o_served_floor (w_sfloor2)
    );

    assign call_ready = r_call_ready;
    assign pend       = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_elv_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elv_dispatch
//  Description : Scoreboard bench for elv_dispatch with a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_elv_dispatch;

    localparam int MOVE_CYCLES = 8;
    localparam int DOOR_CYCLES = 4;

    logic       clk;
    logic       rst;
    logic       call_valid;
    logic [1:0] call_floor;
    logic       call_dir;
    logic       call_ready;
    logic [1:0] pos1;
    logic [1:0] pos2;
    logic       u1;
    logic       u2;
    logic       mv1;
    logic       mv2;
    logic       door1;
    logic       door2;
    logic [3:0] pend;

    int total = 0;
    int bad   = 0;

    elv_dispatch #(
        .MOVE_CYCLES (MOVE_CYCLES),
        .DOOR_CYCLES (DOOR_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .call_valid (call_valid),
        .call_floor (call_floor),
        .call_dir   (call_dir),
        .call_ready (call_ready),
        .pos1       (pos1),
        .pos2       (pos2),
        .u1         (u1),
        .u2         (u2),
        .mv1        (mv1),
        .mv2        (mv2),
        .door1      (door1),
        .door2      (door2),
        .pend       (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] dut_snap();
        return {call_ready, pos1, pos2, u1, u2, mv1, mv2, door1, door2, pend};
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // ---------------- behavioural reference model ----------------
    // Each car: floor, heading, target, cycles left on the current leg,
    // cycles left with doors open.  Floors: up/down flags and owning car.
    int          mpos  [2];
    int          mdir  [2];
    int          mtgt  [2];
    int          mmove [2];
    int          mdoor [2];
    int          mown  [4];
    bit          mup   [4];
    bit          mdn   [4];
    bit          mready;
    logic [14:0] exp_q [$];
    int          svc_q1 [$];
    int          svc_q2 [$];

    always @(posedge clk) begin : model
        int          f;
        int          best;
        bit          acc;
        bit          absorb;
        bit          hold   [2];
        int          ppos   [2];
        int          served [2];
        logic [3:0]  pv;
        if (rst) begin
            mpos[0] = 0; mpos[1] = 3;
            mdir[0] = 0; mdir[1] = 1;
            for (int c = 0; c < 2; c++) begin
                mtgt[c] = -1; mmove[c] = 0; mdoor[c] = 0;
            end
            for (int g = 0; g < 4; g++) begin
                mown[g] = 0; mup[g] = 1'b0; mdn[g] = 1'b0;
            end
            mready = 1'b0;
        end else begin
            acc    = call_valid && mready;
            f      = int'(call_floor);
            absorb = 1'b0;
            for (int c = 0; c < 2; c++) begin
                ppos[c]   = mpos[c];
                hold[c]   = acc && (mdoor[c] > 0) && (mpos[c] == f);
                served[c] = -1;
            end
            for (int c = 0; c < 2; c++) begin
                if (mdoor[c] > 0) begin
                    mdoor[c] = hold[c] ? DOOR_CYCLES : mdoor[c] - 1;
                end else if (mmove[c] > 0) begin
                    mmove[c] = mmove[c] - 1;
                    if (mmove[c] == 0) begin
                        mpos[c] = mpos[c] + ((mdir[c] != 0) ? -1 : 1);
                        if (mpos[c] == mtgt[c]) begin
                            mdoor[c]  = DOOR_CYCLES;
                            served[c] = mpos[c];
                        end else begin
                            mmove[c] = MOVE_CYCLES;
                        end
                    end
                end else begin
                    best = -1;
                    for (int g = 0; g < 4; g++) begin
                        if (mown[g] == c + 1 &&
                            (best < 0 || iabs(g - mpos[c]) < iabs(best - mpos[c]))) best = g;
                    end
                    if (best >= 0) begin
                        mtgt[c] = best;
                        if (best == mpos[c]) begin
                            mdoor[c]  = DOOR_CYCLES;
                            served[c] = best;
                        end else begin
                            mdir[c]  = (best < mpos[c]) ? 1 : 0;
                            mmove[c] = MOVE_CYCLES;
                        end
                    end
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (served[c] >= 0) begin
                    mup[served[c]]  = 1'b0;
                    mdn[served[c]]  = 1'b0;
                    mown[served[c]] = 0;
                    if (acc && served[c] == f) absorb = 1'b1;
                    if (c == 0) svc_q1.push_back(served[c]);
                    else        svc_q2.push_back(served[c]);
                end
            end
            if (hold[0] || hold[1]) absorb = 1'b1;
            if (acc && !absorb) begin
                if (!(mup[f] || mdn[f]))
                    mown[f] = (iabs(ppos[0] - f) <= iabs(ppos[1] - f)) ? 1 : 2;
                if (call_dir) mdn[f] = 1'b1;
                else          mup[f] = 1'b1;
            end
            mready = 1'b1;
        end
        for (int g = 0; g < 4; g++) pv[g] = mup[g] | mdn[g];
        exp_q.push_back({mready, 2'(mpos[0]), 2'(mpos[1]), mdir[0] != 0, mdir[1] != 0,
                         mmove[0] > 0, mmove[1] > 0, mdoor[0] > 0, mdoor[1] > 0, pv});
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [14:0] e;
        logic        pd1;
        logic        pd2;
        pd1 = 1'b0;
        pd2 = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", dut_snap(), e);
                if (door1 === 1'b1 && pd1 === 1'b0) begin
                    check("svc1_expected", svc_q1.size() > 0, 1);
                    if (svc_q1.size() > 0) check("svc1_floor", pos1, svc_q1.pop_front());
                end
                if (door2 === 1'b1 && pd2 === 1'b0) begin
                    check("svc2_expected", svc_q2.size() > 0, 1);
                    if (svc_q2.size() > 0) check("svc2_floor", pos2, svc_q2.pop_front());
                end
                pd1 = door1;
                pd2 = door2;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic call(input int f, input int d);
        call_valid = 1'b1;
        call_floor = 2'(f);
        call_dir   = 1'(d);
        @(negedge clk);
        call_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin : driver
        rst        = 1'b1;
        call_valid = 1'b0;
        call_floor = 2'd0;
        call_dir   = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(20);
        check("t1_idle", dut_snap(), 15'b1_00_11_0_1_0_0_0_0_0000);

        // car1 serves floor 1, car2 stays put
        call(1, 0);
        idle(1);
        check("t2_start", {mv1, pend}, 5'b1_0010);
        idle(MOVE_CYCLES);
        check("t2_arrive", {pos1, door1, pend, pos2, mv2}, {2'd1, 1'b1, 4'b0000, 2'd3, 1'b0});
        idle(20);

        // floor 2 goes to car2; floor 0 then opens car1 without moving
        do_reset();
        call(2, 1);
        idle(1);
        check("t3_car2", {mv2, mv1}, 2'b10);
        call(0, 0);
        idle(1);
        check("t3_door0", {door1, mv1, pend[0]}, 3'b100);
        idle(30);

        // equal distance goes to car1
        do_reset();
        call(1, 0);
        idle(20);
        call(2, 0);
        check("t4_pend", pend, 4'b0100);
        idle(1);
        check("t4_car1", {mv1, mv2}, 2'b10);
        idle(20);

        // repeat call while doors are open is absorbed and holds the door
        do_reset();
        call(1, 0);
        for (int i = 0; i < 30 && door1 !== 1'b1; i++) @(negedge clk);
        check("t5_door", door1, 1'b1);
        call(1, 1);
        check("t5_pend", pend, 4'b0000);
        idle(DOOR_CYCLES - 1);
        check("t5_held", door1, 1'b1);
        idle(10);

        // reset while moving
        do_reset();
        call(1, 0);
        call(2, 0);
        idle(4);
        rst = 1'b1;
        idle(1);
        check("t6_reset", dut_snap(), 15'b0_00_11_0_1_0_0_0_0_0000);
        rst = 1'b0;
        idle(2);

        // randomized traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            rst        = ($urandom_range(0, 399) == 0);
            call_valid = ($urandom_range(0, 3) == 0);
            call_floor = 2'($urandom_range(0, 3));
            call_dir   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rst        = 1'b0;
        call_valid = 1'b0;
        idle(60);
        #1;
        check("svc1_drain", svc_q1.size(), 0);
        check("svc2_drain", svc_q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
